// File: rtl/circuit_breaker.sv
// Trading circuit breaker: escalates IDLE -> WATCH -> HALT on persistent or flash-crash
// alerts, waits for operator ack, then cools down. Optional macro: CB_HALT_CAUSE_EN.
module circuit_breaker #(
    parameter int unsigned WARN_PERSIST = 4,
    parameter int unsigned PRI_HALT_MIN = 5,
    parameter int unsigned CLEAR_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alert_bitmap,
    input  logic [2:0] alert_priority,
    input  logic       ack,
    input  logic [7:0] cooldown_cycles,
    output logic       halt,
    output logic       trade_enable,
    output logic [1:0] cb_state,
    output logic [7:0] sticky_bitmap,
    output logic [7:0] alert_count,
    output logic [7:0] halt_cause
);

    localparam int unsigned PW = (WARN_PERSIST > 1) ? $clog2(WARN_PERSIST + 1) : 1;
    localparam int unsigned QW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;
    localparam logic [PW:0] WARN_LIM  = (PW + 1)'(WARN_PERSIST);
    localparam logic [QW:0] CLEAR_LIM = (QW + 1)'(CLEAR_CYCLES);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWatch    = 2'b01,
        StHalt     = 2'b10,
        StCooldown = 2'b11
    } cb_state_e;

    cb_state_e       state_q;
    logic [PW-1:0]   persist_q;
    logic [QW-1:0]   quiet_q;
    logic [7:0]      cool_q;
    logic            prev_active_q;

    logic            active;
    logic            hot;
    logic            crash;
    logic [PW:0]     persist_inc;
    logic [QW:0]     quiet_inc;
    logic            enter_halt;

    assign active      = (alert_bitmap != 8'h00);
    assign hot         = active && (32'(alert_priority) >= PRI_HALT_MIN);
    assign crash       = alert_bitmap[7];
    // One extra bit so the increment never wraps before the limit compare.
    assign persist_inc = {1'b0, persist_q} + {{PW{1'b0}}, 1'b1};
    assign quiet_inc   = {1'b0, quiet_q} + {{QW{1'b0}}, 1'b1};

    // HALT is re-entered only from other states; a crash while halted just holds.
    assign enter_halt = (state_q != StHalt) &&
                        (crash || (state_q == StWatch && hot && persist_inc >= WARN_LIM));

    assign cb_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            halt          <= 1'b0;
            trade_enable  <= 1'b1;
            persist_q     <= '0;
            quiet_q       <= '0;
            cool_q        <= 8'h00;
            prev_active_q <= 1'b0;
            sticky_bitmap <= 8'h00;
            alert_count   <= 8'h00;
        end else begin
            // New flags win over a simultaneous ack.
            sticky_bitmap <= ack ? alert_bitmap : (sticky_bitmap | alert_bitmap);
            prev_active_q <= active;
            if (active && !prev_active_q && alert_count != 8'hff) begin
                alert_count <= alert_count + 8'd1;
            end

            if (enter_halt) begin
                state_q      <= StHalt;
                halt         <= 1'b1;
                trade_enable <= 1'b0;
                persist_q    <= '0;
                quiet_q      <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (active) begin
                            state_q   <= StWatch;
                            persist_q <= PW'(hot);
                            quiet_q   <= '0;
                        end
                    end
                    StWatch: begin
                        if (hot) begin
                            persist_q <= persist_inc[PW-1:0];
                            quiet_q   <= '0;
                        end else if (active) begin
                            persist_q <= '0;
                            quiet_q   <= '0;
                        end else if (quiet_inc >= CLEAR_LIM) begin
                            state_q   <= StIdle;
                            persist_q <= '0;
                            quiet_q   <= '0;
                        end else begin
                            quiet_q   <= quiet_inc[QW-1:0];
                        end
                    end
                    StHalt: begin
                        if (ack && !crash) begin
                            state_q <= StCooldown;
                            cool_q  <= cooldown_cycles;
                        end
                    end
                    StCooldown: begin
                        if (cool_q == 8'h00) begin
                            state_q      <= StIdle;
                            halt         <= 1'b0;
                            trade_enable <= 1'b1;
                            persist_q    <= '0;
                            quiet_q      <= '0;
                        end else begin
                            cool_q <= cool_q - 8'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef CB_HALT_CAUSE_EN
    logic [7:0] cause_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cause_q <= 8'h00;
        end else if (enter_halt) begin
            cause_q <= alert_bitmap;
        end
    end

    assign halt_cause = cause_q;
`else
    assign halt_cause = 8'h00;
`endif

endmodule

// File: tb/tb_circuit_breaker.sv
// Directed bench for circuit_breaker: a behavioural model checked on every cycle plus
// hand-computed literal checkpoints.
module tb_circuit_breaker;

    logic       clk;
    logic       rst_n;
    logic [7:0] alert_bitmap;
    logic [2:0] alert_priority;
    logic       ack;
    logic [7:0] cooldown_cycles;
    logic       halt;
    logic       trade_enable;
    logic [1:0] cb_state;
    logic [7:0] sticky_bitmap;
    logic [7:0] alert_count;
    logic [7:0] halt_cause;

    circuit_breaker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alert_bitmap   (alert_bitmap),
        .alert_priority (alert_priority),
        .ack            (ack),
        .cooldown_cycles(cooldown_cycles),
        .halt           (halt),
        .trade_enable   (trade_enable),
        .cb_state       (cb_state),
        .sticky_bitmap  (sticky_bitmap),
        .alert_count    (alert_count),
        .halt_cause     (halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CB_HALT_CAUSE_EN
    localparam bit CauseEn = 1'b1;
`else
    localparam bit CauseEn = 1'b0;
`endif

    localparam int Idle = 0, Watch = 1, Halted = 2, Cool = 3;

    int n_total = 0;
    int n_bad   = 0;
    bit check_en = 1'b0;

    // Model state, plain integers.
    int m_state, m_persist, m_quiet, m_cool, m_count;
    int m_sticky, m_cause;
    bit m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic m_go_halt(input int bm);
        m_state   = Halted;
        m_persist = 0;
        m_quiet   = 0;
        if (CauseEn) m_cause = bm;
    endtask

    task automatic m_go_idle();
        m_state   = Idle;
        m_persist = 0;
        m_quiet   = 0;
    endtask

    task automatic model_step();
        int  bm;
        bit  act, hot, crash;
        bm    = int'(alert_bitmap);
        act   = (bm != 0);
        hot   = act && (int'(alert_priority) >= 5);
        crash = alert_bitmap[7];
        if (!rst_n) begin
            m_state = Idle; m_persist = 0; m_quiet = 0; m_cool = 0;
            m_count = 0; m_sticky = 0; m_cause = 0; m_prev = 1'b0;
            return;
        end
        m_sticky = ack ? bm : (m_sticky | bm);
        if (act && !m_prev && m_count < 255) m_count++;
        m_prev = act;
        if (m_state == Idle) begin
            if (crash) m_go_halt(bm);
            else if (act) begin
                m_state   = Watch;
                m_persist = hot ? 1 : 0;
                m_quiet   = 0;
            end
        end else if (m_state == Watch) begin
            if (crash) m_go_halt(bm);
            else if (hot) begin
                m_persist++;
                m_quiet = 0;
                if (m_persist >= 4) m_go_halt(bm);
            end else if (act) begin
                m_persist = 0;
                m_quiet   = 0;
            end else begin
                m_quiet++;
                if (m_quiet >= 8) m_go_idle();
            end
        end else if (m_state == Halted) begin
            if (ack && !crash) begin
                m_state = Cool;
                m_cool  = int'(cooldown_cycles);
            end
        end else begin
            if (crash) m_go_halt(bm);
            else if (m_cool == 0) m_go_idle();
            else m_cool--;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cb_state", 32'(cb_state), m_state);
            chk("halt", 32'(halt), (m_state >= Halted) ? 1 : 0);
            chk("trade_enable", 32'(trade_enable), (m_state >= Halted) ? 0 : 1);
            chk("sticky_bitmap", 32'(sticky_bitmap), m_sticky);
            chk("alert_count", 32'(alert_count), m_count);
            chk("halt_cause", 32'(halt_cause), m_cause);
        end
    end

    task automatic cyc(input logic [7:0] bm, input logic [2:0] pr, input logic a,
                       input logic [7:0] cd);
        alert_bitmap    = bm;
        alert_priority  = pr;
        ack             = a;
        cooldown_cycles = cd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alert_bitmap = 8'h00; alert_priority = 3'd0; ack = 1'b0; cooldown_cycles = 8'd0;
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        check_en = 1'b1;
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("reset_state", 32'(cb_state), 0);
        chk("reset_trade_enable", 32'(trade_enable), 1);
        rst_n = 1'b1;

        // Quiet idle.
        for (int i = 0; i < 20; i++) cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("idle_state", 32'(cb_state), 0);
        chk("idle_halt", 32'(halt), 0);
        chk("idle_count", 32'(alert_count), 0);

        // Hot persistence: WATCH for three visible cycles, then HALT.
        for (int i = 0; i < 5; i++) begin
            cyc(8'h20, 3'd5, 1'b0, 8'd0);
            chk("persist_state", 32'(cb_state), (i < 3) ? 1 : 2);
        end
        chk("persist_cause", 32'(halt_cause), CauseEn ? 32'h20 : 32'h00);
        chk("persist_sticky", 32'(sticky_bitmap), 32'h20);

        // cooldown_cycles = 0 gives one COOLDOWN cycle.
        cyc(8'h00, 3'd0, 1'b1, 8'd0);
        chk("cd0_cool", 32'(cb_state), 3);
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("cd0_idle", 32'(cb_state), 0);

        // Non-hot activity resets the persist count.
        cyc(8'h20, 3'd5, 1'b0, 8'd0);
        cyc(8'h20, 3'd5, 1'b0, 8'd0);
        cyc(8'h20, 3'd5, 1'b0, 8'd0);
        cyc(8'h20, 3'd2, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) cyc(8'h20, 3'd5, 1'b0, 8'd0);
        chk("persist_reset_watch", 32'(cb_state), 1);
        cyc(8'h20, 3'd5, 1'b0, 8'd0);
        chk("persist_reset_halt", 32'(cb_state), 2);
        cyc(8'h00, 3'd0, 1'b1, 8'd0);
        cyc(8'h00, 3'd0, 1'b0, 8'd0);

        // Eight quiet cycles return WATCH to IDLE.
        cyc(8'h01, 3'd0, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("quiet7_watch", 32'(cb_state), 1);
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("quiet8_idle", 32'(cb_state), 0);

        // A pulse at quiet cycle 5 restarts the quiet count.
        cyc(8'h01, 3'd0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) cyc(8'h00, 3'd0, 1'b0, 8'd0);
        cyc(8'h01, 3'd0, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("pulse_watch", 32'(cb_state), 1);
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("pulse_idle", 32'(cb_state), 0);

        // Flash crash, ignored ack, cooldown of 3 lasts four cycles.
        cyc(8'h80, 3'd0, 1'b0, 8'd0);
        chk("crash_halt", 32'(cb_state), 2);
        chk("crash_cause", 32'(halt_cause), CauseEn ? 32'h80 : 32'h00);
        cyc(8'h80, 3'd0, 1'b1, 8'd3);
        chk("ack_ignored", 32'(cb_state), 2);
        cyc(8'h00, 3'd0, 1'b1, 8'd3);
        chk("cool_enter", 32'(cb_state), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 3'd0, 1'b0, 8'd0);
            chk("cool_hold", 32'(cb_state), 3);
        end
        cyc(8'h00, 3'd0, 1'b0, 8'd0);
        chk("cool_done", 32'(cb_state), 0);
        chk("cool_trade_enable", 32'(trade_enable), 1);

        // Crash during cooldown, ack alongside new flags.
        cyc(8'h80, 3'd0, 1'b0, 8'd0);
        cyc(8'h00, 3'd0, 1'b1, 8'd5);
        chk("cool2_enter", 32'(cb_state), 3);
        cyc(8'h80, 3'd0, 1'b0, 8'd0);
        chk("cool_crash_halt", 32'(cb_state), 2);
        cyc(8'h04, 3'd0, 1'b1, 8'd0);
        chk("ack_new_flags", 32'(sticky_bitmap), 32'h04);
        cyc(8'h00, 3'd0, 1'b0, 8'd0);

        // Alert onsets saturate at 255 and survive ack.
        for (int i = 0; i < 300; i++) begin
            cyc(8'h01, 3'd0, 1'b0, 8'd0);
            cyc(8'h00, 3'd0, 1'b0, 8'd0);
        end
        chk("count_sat", 32'(alert_count), 255);
        cyc(8'h00, 3'd0, 1'b1, 8'd0);
        chk("count_after_ack", 32'(alert_count), 255);

        // Reset overrides HALT.
        cyc(8'h80, 3'd0, 1'b0, 8'd0);
        chk("pre_reset_halt", 32'(cb_state), 2);
        rst_n = 1'b0;
        cyc(8'h80, 3'd0, 1'b0, 8'd0);
        chk("rst_state", 32'(cb_state), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_sticky", 32'(sticky_bitmap), 0);
        chk("rst_cause", 32'(halt_cause), 0);
        chk("rst_count", 32'(alert_count), 0);
        rst_n = 1'b1;
        cyc(8'h00, 3'd0, 1'b0, 8'd0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/circuit_breaker.md
CIRCUIT_BREAKER -- requirements
Module: circuit_breaker

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  - WARN_PERSIST, 4: WATCH cycles at high priority before HALT.
  - PRI_HALT_MIN, 5: minimum alert_priority counted toward persistence.
  - CLEAR_CYCLES, 8: consecutive quiet cycles that return WATCH to IDLE.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 alert_bitmap  in  8  detector flags from the anomaly detector; bit7 = flash crash.
REQ-005 alert_priority  in  3  highest active priority from the anomaly detector.
REQ-006 ack  in  1  operator acknowledge, single-cycle pulse.
REQ-007 cooldown_cycles  in  8  post-acknowledge cooldown length, sampled on HALT->COOLDOWN.
REQ-008 halt  out  1  trading halted (1 in HALT and COOLDOWN).
REQ-009 trade_enable  out  1  inverse of halt.
REQ-010 cb_state  out  2  state: 00 IDLE, 01 WATCH, 10 HALT, 11 COOLDOWN.
REQ-011 sticky_bitmap  out  8  OR of all flags seen since last ack.
REQ-012 alert_count  out  8  saturating count of alert onsets.
REQ-013 halt_cause  out  8  bitmap captured at HALT entry (see Configuration).

Function
REQ-014 All outputs SHALL be registered; a given input cycle is reflected at the outputs one cycle later.
REQ-015 "Active" SHALL mean alert_bitmap != 0; "hot" SHALL mean active and alert_priority >= PRI_HALT_MIN.
REQ-016 IDLE: bit7 set -> HALT; else active -> WATCH (persist counter = 1 if hot, else 0); else stay.
REQ-017 WATCH: bit7 set -> HALT, taking priority over all other transitions.
  - Hot: persist counter += 1; HALT when it reaches WARN_PERSIST.
  - Active but not hot: persist counter resets to 0.
  - Not active: quiet counter += 1, else quiet counter = 0; IDLE when quiet counter reaches CLEAR_CYCLES.
REQ-018 HALT: hold until ack=1 with bit7=0 in the same cycle, then COOLDOWN with down-counter = cooldown_cycles; ack while bit7=1 SHALL be ignored.
REQ-019 COOLDOWN: bit7 set -> HALT; else counter = 0 -> IDLE; else decrement; cooldown_cycles = 0 SHALL give exactly one COOLDOWN cycle.
REQ-020 Persist and quiet counters SHALL clear on every entry to IDLE or HALT; both SHALL be wide enough for their parameters without wrap.
REQ-021 sticky_bitmap update per cycle:
  - No ack: sticky | alert_bitmap.
  - ack=1: cleared to the current alert_bitmap (new flags win over simultaneous ack).
REQ-022 alert_count SHALL increment when active and the previous cycle was not active, saturating at 255; ack SHALL NOT clear it.
REQ-023 ack in IDLE or WATCH SHALL only affect sticky_bitmap.

Reset
REQ-024 On rst_n=0 at a clock edge, the block SHALL set the following, overriding any operation in progress including HALT:
  - cb_state = IDLE; halt = 0; trade_enable = 1.
  - sticky_bitmap = 0; alert_count = 0; halt_cause = 0.
  - All internal counters = 0; previous-active flag = 0.

Configuration
REQ-025 With macro CB_HALT_CAUSE_EN defined:
  - halt_cause SHALL load alert_bitmap on every transition into HALT.
  - It SHALL hold that value until the next HALT entry or reset.
REQ-026 Without CB_HALT_CAUSE_EN, halt_cause SHALL be constant 0, the port SHALL remain present, and no capture register SHALL be built.

Verification
REQ-027 Reset, bitmap=0x00 for 20 cycles -> cb_state=00, halt=0, trade_enable=1, alert_count=0.
REQ-028 bitmap=0x20 with priority=5 for 5 cycles from IDLE -> WATCH, then HALT at the fourth WATCH cycle; halt_cause=0x20 with macro, 0x00 without.
REQ-029 In WATCH, bitmap=0x00 for 8 cycles -> IDLE; a single-cycle bitmap=0x01 at quiet cycle 5 -> quiet counter restarts and IDLE is reached 8 cycles after that pulse.
REQ-030 IDLE, bitmap=0x80 for one cycle -> HALT next cycle; ack with bitmap=0x80 -> stays HALT; ack with bitmap=0x00 and cooldown_cycles=3 -> COOLDOWN for 4 cycles, then IDLE with trade_enable=1.
REQ-031 COOLDOWN, bitmap=0x80 -> HALT; ack coinciding with bitmap=0x04 -> sticky_bitmap=0x04; 300 alternating 0x01/0x00 cycles -> alert_count=255.
REQ-032 rst_n=0 for one cycle while in HALT -> next cycle cb_state=00, halt=0, sticky_bitmap=0, halt_cause=0.
